line_clearer: RTL

Post-lock line-clear engine for the Tetris board. It is started by the game datapath after a tetromino has been written into the board state. It scans the board bottom-up one row per cycle, removes every full row and compacts the remaining rows downward. It then zero-fills the vacated top rows and reports the number of lines cleared plus an accumulated score. It owns no board storage: it accesses the board through a row-wide read port and a row-wide write port.

---
 rtl/tetris_pkg.sv | 22 ++
 rtl/line_score_accum.sv | 44 ++++
 rtl/line_clearer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/tetris_pkg.sv
// Shared Tetris definitions: board geometry, line-clear FSM states and the
// per-pass score table values.
package tetris_pkg;

  localparam int BOARD_ROWS = 23;
  localparam int BOARD_COLS = 10;

  // Line-clear engine states
  typedef enum logic [1:0] {
    LC_IDLE,
    LC_SCAN,
    LC_FILL,
    LC_DONE
  } lc_state_t;

  // Points awarded for clearing 1, 2, 3 and 4-or-more lines in one pass
  localparam int SCORE_1L = 40;
  localparam int SCORE_2L = 100;
  localparam int SCORE_3L = 300;
  localparam int SCORE_4L = 1200;

endpackage

// File: rtl/line_score_accum.sv
// Score accumulator step: maps the number of lines cleared in a pass to its
// table value and adds it to the running score, clamping at the all-ones
// value so the score never wraps. Purely combinational.
module line_score_accum
  import tetris_pkg::*;
#(
  parameter int SCORE_W = 20
) (
  input  logic [4:0]         lines,
  input  logic [SCORE_W-1:0] score_cur,
  output logic [SCORE_W-1:0] score_next
);

  // Wide enough for the largest award and one carry bit beyond the score
  localparam int SUM_W = ((SCORE_W > 11) ? SCORE_W : 11) + 1;
  localparam logic [SUM_W-1:0] SCORE_MAX =
    {{(SUM_W - SCORE_W){1'b0}}, {SCORE_W{1'b1}}};

  logic [SUM_W-1:0] award;
  logic [SUM_W-1:0] sum;

  // Table lookup, then saturating add
  always_comb begin
    // NOTE: every variable written in a combinational block gets a default
    // first so no path leaves it unassigned (which would infer a latch).
    award      = '0;
    sum        = '0;
    score_next = '0;
    case (lines)
      5'd0:    award = '0;
      5'd1:    award = SUM_W'(SCORE_1L);
      5'd2:    award = SUM_W'(SCORE_2L);
      5'd3:    award = SUM_W'(SCORE_3L);
      default: award = SUM_W'(SCORE_4L);
    endcase
    sum = {{(SUM_W - SCORE_W){1'b0}}, score_cur} + award;
    if (sum > SCORE_MAX) begin
      score_next = SCORE_MAX[SCORE_W-1:0];
    end else begin
      score_next = sum[SCORE_W-1:0];
    end
  end

endmodule

// File: rtl/line_clearer.sv
// Post-lock line-clear engine. Scans the board bottom-up one row per cycle
// through a combinational row read port, drops full rows by copying the
// surviving rows down (write pointer never passes the read pointer), then
// zero-fills the vacated top rows and reports the lines cleared.
// Optional feature macro: LINE_CLEAR_SCORE_EN compiles in the saturating
// score accumulator; without it score is tied to zero.
module line_clearer
  import tetris_pkg::*;
#(
  parameter int ROWS    = BOARD_ROWS,
  parameter int COLS    = BOARD_COLS,
  parameter int SCORE_W = 20
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [4:0]         row_raddr,
  input  logic [COLS-1:0]    row_rdata,
  output logic               row_we,
  output logic [4:0]         row_waddr,
  output logic [COLS-1:0]    row_wdata,
  output logic [4:0]         lines_cleared,
  output logic [SCORE_W-1:0] score
);

  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  lc_state_t  state, state_next;
  logic [4:0] rd, rd_next;
  logic [4:0] wr, wr_next;
  logic [4:0] cnt, cnt_next;
  logic [4:0] lines_q;
  logic       row_full;

  assign row_full = &row_rdata;

  // FSM state and scan pointers
  always_ff @(posedge clock) begin
    // NOTE: reset is synchronous (sampled only on the clock edge), and all
    // state uses non-blocking assignment so every register sees the
    // pre-edge values of the others.
    if (reset) begin
      state <= LC_IDLE;
      rd    <= '0;
      wr    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      rd    <= rd_next;
      wr    <= wr_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state, pointer updates and board-port drive
  always_comb begin
    state_next = state;
    rd_next    = rd;
    wr_next    = wr;
    cnt_next   = cnt;
    busy       = 1'b0;
    done       = 1'b0;
    row_raddr  = '0;
    row_we     = 1'b0;
    row_waddr  = '0;
    row_wdata  = '0;
    case (state)
      LC_IDLE: begin
        if (start) begin
          state_next = LC_SCAN;
          rd_next    = '0;
          wr_next    = '0;
          cnt_next   = '0;
        end
      end
      LC_SCAN: begin
        busy      = 1'b1;
        row_raddr = rd;
        if (row_full) begin
          cnt_next = cnt + 5'd1;
        end else begin
          // A surviving row only needs moving once something below it went
          if (wr != rd) begin
            row_we    = 1'b1;
            row_waddr = wr;
            row_wdata = row_rdata;
          end
          wr_next = wr + 5'd1;
        end
        rd_next = rd + 5'd1;
        if (rd == LAST_ROW) begin
          state_next = (cnt_next != 5'd0) ? LC_FILL : LC_DONE;
        end
      end
      LC_FILL: begin
        busy      = 1'b1;
        row_we    = 1'b1;
        row_waddr = wr;
        wr_next   = wr + 5'd1;
        if (wr == LAST_ROW) begin
          state_next = LC_DONE;
        end
      end
      LC_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = LC_IDLE;
      end
      default: state_next = LC_IDLE;
    endcase
  end

  // Lines-cleared result register, loaded at the edge ending DONE
  always_ff @(posedge clock) begin
    if (reset) begin
      lines_q <= '0;
    end else if (state == LC_DONE) begin
      lines_q <= cnt;
    end
  end

  // The fresh count is forwarded during DONE so it is valid with the pulse
  assign lines_cleared = (state == LC_DONE) ? cnt : lines_q;

`ifdef LINE_CLEAR_SCORE_EN
  logic [SCORE_W-1:0] score_q;
  logic [SCORE_W-1:0] score_sum;

  line_score_accum #(
    .SCORE_W(SCORE_W)
  ) u_score (
    .lines     (cnt),
    .score_cur (score_q),
    .score_next(score_sum)
  );

  // Accumulated score, updated once per pass at the edge ending DONE
  always_ff @(posedge clock) begin
    if (reset) begin
      score_q <= '0;
    end else if (state == LC_DONE) begin
      score_q <= score_sum;
    end
  end

  assign score = (state == LC_DONE) ? score_sum : score_q;
`else
  assign score = '0;
`endif

endmodule
